alu_op_sequencer: RTL and testbench

//  Requester-side driver for the 4-bit-control, 32-bit combinational ALU (ALUControl/DataIn0/DataIn1 -> DataOut/ZeroOut).

---
 rtl/alu_op_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
//
// Requester-side driver for a 4-bit-control, WIDTH-bit combinational ALU.
// A single operation request (MIPS ALUOp + funct + two operands) is accepted
// over a valid/ready handshake. The request is decoded to an ALUControl code,
// and the code and operands are registered onto the ALU inputs. The ALU result
// and zero flag are captured one cycle later and returned on a valid/ready
// response channel.
//
// Ports
//   clk, reset                     clock (rising edge), synchronous active-high reset
//   req_valid / req_ready          request handshake
//   req_aluop, req_funct           operation selector (funct used only for aluop 10)
//   req_a, req_b                   operands
//   ALUControl, DataIn0, DataIn1   registered drive into the ALU
//   DataOut, ZeroOut               combinational ALU result / zero flag
//   rsp_valid / rsp_ready          response handshake
//   rsp_data, rsp_zero             captured ALU result / zero flag
//   rsp_illegal                    request could not be decoded
//   op_count                       responses handed off (wraps)
//
// Operation flow: IDLE (accept) -> EXEC (ALU inputs stable for a full cycle,
// result captured at the closing edge) -> RESP (hold until consumer takes it).
// -----------------------------------------------------------------------------
module alu_op_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_aluop,
    input  logic [5:0]       req_funct,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,

    output logic [3:0]       ALUControl,
    output logic [WIDTH-1:0] DataIn0,
    output logic [WIDTH-1:0] DataIn1,
    input  logic [WIDTH-1:0] DataOut,
    input  logic             ZeroOut,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero,
    output logic             rsp_illegal,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    // R-type funct table: entry k occupies bits [6k +: 6] / [4k +: 4].
    // add, sub, and, or, slt, nor
    localparam int          N_FUNCT     = 6;
    localparam logic [35:0] FUNCT_CODES = {6'b100111, 6'b101010, 6'b100101,
                                           6'b100100, 6'b100010, 6'b100000};
    localparam logic [23:0] FUNCT_CTRLS = {4'b1100, 4'b0111, 4'b0001,
                                           4'b0000, 4'b0110, 4'b0010};

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    state_t             state_reg,       state_next;
    logic               req_ready_reg,   req_ready_next;
    logic [3:0]         alu_ctrl_reg,    alu_ctrl_next;
    logic [WIDTH-1:0]   din0_reg,        din0_next;
    logic [WIDTH-1:0]   din1_reg,        din1_next;
    logic               illegal_reg,     illegal_next;
    logic               rsp_valid_reg,   rsp_valid_next;
    logic [WIDTH-1:0]   rsp_data_reg,    rsp_data_next;
    logic               rsp_zero_reg,    rsp_zero_next;
    logic               rsp_illegal_reg, rsp_illegal_next;
    logic [CNT_W-1:0]   op_count_reg,    op_count_next;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic [N_FUNCT-1:0] funct_hit;
    logic [3:0]         dec_ctrl;
    logic               dec_illegal;

    genvar gi;
    generate
        for (gi = 0; gi < N_FUNCT; gi++) begin : g_funct_match
            assign funct_hit[gi] = (req_funct == FUNCT_CODES[gi*6 +: 6]);
        end
    endgenerate

    always_comb begin
        dec_ctrl    = 4'b0000;
        dec_illegal = 1'b0;
        case (req_aluop)
            2'b00: dec_ctrl = 4'b0010;
            2'b01: dec_ctrl = 4'b0110;
            2'b10: begin
                // Table codes are unique, so at most one hit is set.
                dec_illegal = ~|funct_hit;
                for (int i = 0; i < N_FUNCT; i++) begin
                    if (funct_hit[i]) begin
                        dec_ctrl = FUNCT_CTRLS[i*4 +: 4];
                    end
                end
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state / next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next       = state_reg;
        req_ready_next   = req_ready_reg;
        alu_ctrl_next    = alu_ctrl_reg;
        din0_next        = din0_reg;
        din1_next        = din1_reg;
        illegal_next     = illegal_reg;
        rsp_valid_next   = rsp_valid_reg;
        rsp_data_next    = rsp_data_reg;
        rsp_zero_next    = rsp_zero_reg;
        rsp_illegal_next = rsp_illegal_reg;
        op_count_next    = op_count_reg;

        case (state_reg)
            IDLE: begin
                // req_ready is low for one cycle after reset, so a request
                // is only taken once the handshake has actually been offered.
                if (req_valid && req_ready_reg) begin
                    state_next     = EXEC;
                    req_ready_next = 1'b0;
                    illegal_next   = dec_illegal;
                    // An undecodable request leaves the ALU inputs untouched
                    // so the ALU sees no toggling for a request it cannot run.
                    if (!dec_illegal) begin
                        alu_ctrl_next = dec_ctrl;
                        din0_next     = req_a;
                        din1_next     = req_b;
                    end
                end else begin
                    req_ready_next = 1'b1;
                end
            end

            EXEC: begin
                state_next     = RESP;
                rsp_valid_next = 1'b1;
                if (illegal_reg) begin
                    rsp_data_next    = '0;
                    rsp_zero_next    = 1'b0;
                    rsp_illegal_next = 1'b1;
                end else begin
                    rsp_data_next    = DataOut;
                    rsp_zero_next    = ZeroOut;
                    rsp_illegal_next = 1'b0;
                end
            end

            RESP: begin
                if (rsp_ready) begin
                    state_next     = IDLE;
                    rsp_valid_next = 1'b0;
                    req_ready_next = 1'b1;
                    op_count_next  = op_count_reg + CNT_W'(1);
                end
            end

            default: begin
                state_next     = IDLE;
                req_ready_next = 1'b0;
                rsp_valid_next = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            req_ready_reg   <= 1'b0;
            alu_ctrl_reg    <= 4'b0000;
            din0_reg        <= '0;
            din1_reg        <= '0;
            illegal_reg     <= 1'b0;
            rsp_valid_reg   <= 1'b0;
            rsp_data_reg    <= '0;
            rsp_zero_reg    <= 1'b0;
            rsp_illegal_reg <= 1'b0;
            op_count_reg    <= '0;
        end else begin
            state_reg       <= state_next;
            req_ready_reg   <= req_ready_next;
            alu_ctrl_reg    <= alu_ctrl_next;
            din0_reg        <= din0_next;
            din1_reg        <= din1_next;
            illegal_reg     <= illegal_next;
            rsp_valid_reg   <= rsp_valid_next;
            rsp_data_reg    <= rsp_data_next;
            rsp_zero_reg    <= rsp_zero_next;
            rsp_illegal_reg <= rsp_illegal_next;
            op_count_reg    <= op_count_next;
        end
    end

    assign req_ready   = req_ready_reg;
    assign ALUControl  = alu_ctrl_reg;
    assign DataIn0     = din0_reg;
    assign DataIn1     = din1_reg;
    assign rsp_valid   = rsp_valid_reg;
    assign rsp_data    = rsp_data_reg;
    assign rsp_zero    = rsp_zero_reg;
    assign rsp_illegal = rsp_illegal_reg;
    assign op_count    = op_count_reg;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_op_sequencer
//
// Drives directed operations through alu_op_sequencer with a behavioural ALU
// attached. Expected outputs come from a transaction-level reference
// (operation semantics computed directly from aluop/funct and the operands);
// a compare process checks every DUT output on each falling edge, and the
// directed sequence adds hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_alu_op_sequencer;

    localparam int WIDTH = 32;
    localparam int CNT_W = 16;

    logic             clk;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_aluop;
    logic [5:0]       req_funct;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [3:0]       ALUControl;
    logic [WIDTH-1:0] DataIn0;
    logic [WIDTH-1:0] DataIn1;
    logic [WIDTH-1:0] DataOut;
    logic             ZeroOut;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_zero;
    logic             rsp_illegal;
    logic [CNT_W-1:0] op_count;

    alu_op_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_aluop   (req_aluop),
        .req_funct   (req_funct),
        .req_a       (req_a),
        .req_b       (req_b),
        .ALUControl  (ALUControl),
        .DataIn0     (DataIn0),
        .DataIn1     (DataIn1),
        .DataOut     (DataOut),
        .ZeroOut     (ZeroOut),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_zero    (rsp_zero),
        .rsp_illegal (rsp_illegal),
        .op_count    (op_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural combinational ALU
    always_comb begin
        case (ALUControl)
            4'b0010: DataOut = DataIn0 + DataIn1;
            4'b0110: DataOut = DataIn0 - DataIn1;
            4'b0000: DataOut = DataIn0 & DataIn1;
            4'b0001: DataOut = DataIn0 | DataIn1;
            4'b0111: DataOut = ($signed(DataIn0) < $signed(DataIn1)) ? 32'd1 : 32'd0;
            4'b1100: DataOut = ~(DataIn0 | DataIn1);
            default: DataOut = 32'd0;
        endcase
        ZeroOut = (DataOut == 32'd0);
    end

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;
    bit chk_on   = 1'b0;

    logic             exp_req_ready;
    logic [3:0]       exp_ctrl;
    logic [WIDTH-1:0] exp_din0;
    logic [WIDTH-1:0] exp_din1;
    logic             exp_rsp_valid;
    logic [WIDTH-1:0] exp_rsp_data;
    logic             exp_rsp_zero;
    logic             exp_rsp_illegal;
    logic [CNT_W-1:0] exp_count;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference semantics of one request.
    function automatic void ref_op(input logic [1:0] aluop, input logic [5:0] funct,
                                   input logic [31:0] a, input logic [31:0] b,
                                   output logic [3:0] ctrl, output logic ill,
                                   output logic [31:0] res);
        ctrl = 4'b0000;
        ill  = 1'b0;
        res  = 32'd0;
        case (aluop)
            2'b00: begin ctrl = 4'b0010; res = a + b; end
            2'b01: begin ctrl = 4'b0110; res = a - b; end
            2'b10: begin
                case (funct)
                    6'h20:   begin ctrl = 4'b0010; res = a + b;    end
                    6'h22:   begin ctrl = 4'b0110; res = a - b;    end
                    6'h24:   begin ctrl = 4'b0000; res = a & b;    end
                    6'h25:   begin ctrl = 4'b0001; res = a | b;    end
                    6'h2a:   begin ctrl = 4'b0111; res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
                    6'h27:   begin ctrl = 4'b1100; res = ~(a | b); end
                    default: ill = 1'b1;
                endcase
            end
            default: ill = 1'b1;
        endcase
    endfunction

    task automatic set_reset_expect();
        exp_req_ready   = 1'b0;
        exp_ctrl        = 4'b0000;
        exp_din0        = '0;
        exp_din1        = '0;
        exp_rsp_valid   = 1'b0;
        exp_rsp_data    = '0;
        exp_rsp_zero    = 1'b0;
        exp_rsp_illegal = 1'b0;
        exp_count       = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare process: every output, every cycle after the first reset edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                check("req_ready",   req_ready,   exp_req_ready);
                check("ALUControl",  ALUControl,  exp_ctrl);
                check("DataIn0",     DataIn0,     exp_din0);
                check("DataIn1",     DataIn1,     exp_din1);
                check("rsp_valid",   rsp_valid,   exp_rsp_valid);
                check("rsp_data",    rsp_data,    exp_rsp_data);
                check("rsp_zero",    rsp_zero,    exp_rsp_zero);
                check("rsp_illegal", rsp_illegal, exp_rsp_illegal);
                check("op_count",    op_count,    exp_count);
            end
        end
    end

    // One complete operation; entered 1ns after an edge with the DUT idle.
    // hold: cycles rsp_ready stays low in RESP. abort: reset while in RESP.
    task automatic do_op(input logic [1:0] aluop, input logic [5:0] funct,
                         input logic [31:0] a, input logic [31:0] b,
                         input int hold, input bit abort);
        logic [3:0]  c;
        logic        il;
        logic [31:0] r;
        ref_op(aluop, funct, a, b, c, il, r);
        req_valid = 1'b1;
        req_aluop = aluop;
        req_funct = funct;
        req_a     = a;
        req_b     = b;
        // rsp_ready high before RESP must have no effect.
        rsp_ready = (hold == 0) && !abort;
        tick();                                   // accept edge
        exp_req_ready = 1'b0;
        if (!il) begin
            exp_ctrl = c;
            exp_din0 = a;
            exp_din1 = b;
        end
        // A competing request while busy must be ignored.
        req_aluop = 2'b10;
        req_funct = 6'h27;
        req_a     = 32'hDEAD_BEEF;
        req_b     = 32'h0000_1234;
        tick();                                   // edge closing EXEC
        exp_rsp_valid   = 1'b1;
        exp_rsp_data    = il ? 32'd0 : r;
        exp_rsp_zero    = !il && (r == 32'd0);
        exp_rsp_illegal = il;
        for (int i = 0; i < hold; i++) tick();
        if (abort) begin
            reset = 1'b1;
            tick();
            set_reset_expect();
            reset     = 1'b0;
            req_valid = 1'b0;
            tick();
            exp_req_ready = 1'b1;
            return;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();                                   // hand-off edge
        exp_rsp_valid = 1'b0;
        exp_req_ready = 1'b1;
        exp_count     = exp_count + 1'b1;
        rsp_ready     = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_aluop = 2'b00;
        req_funct = 6'd0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;

        // 1) two reset cycles
        tick();
        set_reset_expect();
        chk_on = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        exp_req_ready = 1'b1;
        check("t1_req_ready", req_ready, 1);
        check("t1_rsp_valid", rsp_valid, 0);

        // 2) add 1+2
        do_op(2'b00, 6'd0, 32'd1, 32'd2, 0, 1'b0);
        check("t2_data", rsp_data, 3);
        check("t2_zero", rsp_zero, 0);
        check("t2_ctrl", ALUControl, 4'b0010);
        check("t2_count", op_count, 1);

        // 3) slt
        do_op(2'b10, 6'b101010, 32'd1, 32'd2, 0, 1'b0);
        check("t3_ctrl", ALUControl, 4'b0111);
        check("t3_data_lt", rsp_data, 1);
        do_op(2'b10, 6'b101010, 32'd4, 32'd2, 0, 1'b0);
        check("t3_data_ge", rsp_data, 0);
        do_op(2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1, 0, 1'b0);
        check("t3_data_neg", rsp_data, 1);

        // 4) sub / beq
        do_op(2'b01, 6'd0, 32'd4, 32'd4, 0, 1'b0);
        check("t4_ctrl", ALUControl, 4'b0110);
        check("t4_zero_eq", rsp_zero, 1);
        do_op(2'b01, 6'd0, 32'd4, 32'd2, 0, 1'b0);
        check("t4_zero_ne", rsp_zero, 0);
        check("t4_data", rsp_data, 2);

        // 5) illegal funct: ALU inputs keep the previous op's values
        do_op(2'b10, 6'b000000, 32'd7, 32'd9, 0, 1'b0);
        check("t5_illegal", rsp_illegal, 1);
        check("t5_data", rsp_data, 0);
        check("t5_ctrl", ALUControl, 4'b0110);
        check("t5_din0", DataIn0, 4);

        // other R-type ops, aluop 11, overflow wrap
        do_op(2'b10, 6'b100100, 32'hF0F0_00FF, 32'h0FF0_0F0F, 0, 1'b0);
        check("and_data", rsp_data, 32'h00F0_000F);
        do_op(2'b10, 6'b100111, 32'hF0F0_0000, 32'h0000_0F0F, 0, 1'b0);
        check("nor_data", rsp_data, 32'h0F0F_F0F0);
        do_op(2'b10, 6'b100010, 32'd3, 32'd5, 0, 1'b0);
        check("sub_data", rsp_data, 32'hFFFF_FFFE);
        do_op(2'b11, 6'b100000, 32'd1, 32'd1, 0, 1'b0);
        check("aluop11_illegal", rsp_illegal, 1);
        check("aluop11_ctrl", ALUControl, 4'b0110);
        do_op(2'b10, 6'b100000, 32'hFFFF_FFFF, 32'd1, 0, 1'b0);
        check("ovf_data", rsp_data, 0);
        check("ovf_zero", rsp_zero, 1);
        check("ovf_illegal", rsp_illegal, 0);

        // 6) back-pressure, then reset while in RESP
        do_op(2'b00, 6'd0, 32'd5, 32'd6, 5, 1'b0);
        check("t6_data", rsp_data, 11);
        check("t6_count", op_count, 13);
        do_op(2'b00, 6'd0, 32'd9, 32'd9, 2, 1'b1);
        check("t6_abort_valid", rsp_valid, 0);
        check("t6_abort_count", op_count, 0);

        // recovery after abort
        do_op(2'b10, 6'b100101, 32'h0000_00F0, 32'h0000_000F, 0, 1'b0);
        check("or_data", rsp_data, 32'h0000_00FF);
        check("post_count", op_count, 1);

        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
